// File: rtl/imem_loader.sv
// Streams a program, high byte first, into the instruction memory write port and holds the CPU until DEPTH words are written.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count,
   output logic              chk_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE, CHECK} state_t;
   logic [7:0] xor_q;
   logic       chk_err_q;
`else
   typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t              state_q;
   logic [7:0]          hi_q;
   logic                ready_q;
   logic                we_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                hold_q;
   logic                busy_q;
   logic                done_q;
   logic [ADDR_W:0]     count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q     <= '0;
         chk_err_q <= 1'b0;
`endif
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               // start beats abort here: abort only means something inside a session
               if (start) begin
                  state_q <= HI;
                  ready_q <= 1'b1;
                  waddr_q <= '0;
                  count_q <= '0;
                  done_q  <= 1'b0;
                  hold_q  <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_q     <= '0;
                  chk_err_q <= 1'b0;
`endif
               end
            end
            HI: begin
               if (abort) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                  hold_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else if (byte_valid && ready_q) begin
                  hi_q    <= byte_in;
                  state_q <= LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_q <= xor_q ^ byte_in;
`endif
               end
            end
            LO: begin
               if (abort) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                  hold_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else if (byte_valid && ready_q) begin
                  wdata_q <= {hi_q, byte_in};
                  we_q    <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_q <= xor_q ^ byte_in;
`endif
               end
            end
            WRITE: begin
               // the strobe is already out this cycle, so an abort only redirects what follows
               count_q <= count_q + (ADDR_W+1)'(1);
               if (abort) begin
                  state_q <= IDLE;
                  hold_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else if (waddr_q == LAST_ADDR) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_q <= CHECK;
                  ready_q <= 1'b1;
`else
                  state_q <= DONE;
                  hold_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
               end else begin
                  waddr_q <= waddr_q + ADDR_W'(1);
                  ready_q <= 1'b1;
                  state_q <= HI;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (abort) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                  hold_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else if (byte_valid && ready_q) begin
                  chk_err_q <= (byte_in != xor_q);
                  state_q   <= DONE;
                  ready_q   <= 1'b0;
                  hold_q    <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               hold_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready = ready_q;
   assign imem_we    = we_q;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign word_count = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign chk_err    = chk_err_q;
`else
   assign chk_err    = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the 16x16 instruction memory: streams a program into the memory's write port.
- Accepts bytes over a valid/ready handshake, high byte first, and assembles them into 16-bit instruction words.
- Writes each word to consecutive addresses starting at 0.
- Holds the CPU stalled (cpu_hold) from start until all DEPTH words are written, then releases it and flags done.

Parameters:
- ADDR_W, 4, instruction memory address width.
- DATA_W, 16, instruction width; fixed at two bytes.
- DEPTH, 16, number of words loaded per session; equals 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load session; sampled only in IDLE or DONE.
- abort  input  1  cancel an active session.
- byte_in  input  8  program byte.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader accepts byte_in this cycle.
- imem_we  output  1  write strobe to the instruction memory.
- imem_waddr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  write data.
- cpu_hold  output  1  stall/hold request to the CPU while loading.
- busy  output  1  session active.
- done  output  1  DEPTH words written; sticky until the next start or rst.
- word_count  output  ADDR_W+1  words written this session (0..DEPTH).
- chk_err  output  1  checksum mismatch; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, word_count, chk_err.
  - Reset takes priority over every other input, including mid-session. Words already written stay in memory.
- States: IDLE, HI, LO, WRITE, DONE (plus CHECK with the optional feature). All outputs are Moore, decoded from registered state and datapath registers.
- IDLE/DONE:
  - byte_ready=0.
  - On start=1: go to HI; clear imem_waddr, word_count, done and chk_err; set cpu_hold=1 and busy=1.
- HI:
  - byte_ready=1.
  - A transfer happens when byte_valid&&byte_ready. On a transfer, latch byte_in into hi_reg and go to LO.
  - byte_valid=0 means wait indefinitely.
- LO:
  - byte_ready=1.
  - On a transfer, imem_wdata <= {hi_reg, byte_in}, then go to WRITE.
- WRITE:
  - byte_ready=0; imem_we=1 for exactly one cycle, with imem_waddr and imem_wdata stable.
  - word_count increments.
  - If imem_waddr==DEPTH-1: go to DONE (or CHECK). Otherwise imem_waddr increments and the state goes to HI.
- DONE:
  - done=1, cpu_hold=0, busy=0.
  - imem_waddr holds DEPTH-1; it never wraps to 0 within a session.
- Throughput: minimum 3 cycles per word. 48 cycles from the first HI to DONE with byte_valid held high.
- abort=1 in HI, LO or CHECK: go to IDLE at the next edge; cpu_hold=0, busy=0, done=0.
- abort in WRITE: the write completes, then the loader goes to IDLE instead of HI/DONE.
- start while busy is ignored.
- abort and start asserted together in IDLE/DONE: start wins (abort has no effect outside a session).
- imem_we is never asserted outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all 2*DEPTH accepted bytes is kept and cleared on start.
  - After the last WRITE the loader enters CHECK with byte_ready=1 and accepts one extra byte.
  - If that byte does not equal the running XOR, chk_err=1. It is sticky until the next start or rst.
  - The loader then goes to DONE.
- Undefined: no CHECK state and no checksum register; chk_err is tied 0.

Test Plan:
- Reset, start, then 32 bytes 0x70,0x16,0x65,0x16,... with byte_valid held high:
  - 16 single-cycle imem_we pulses at addr 0..15; word 0 = 0x7016, word 1 = 0x6516.
  - done=1 and cpu_hold=0 48 cycles after start; word_count=16.
- Random byte_valid gaps, including between the HI and LO bytes: identical write sequence, no dropped or duplicated bytes, byte_ready=0 in WRITE.
- start pulsed in the middle of word 5: ignored; session completes normally.
- abort in the LO of word 3: IDLE next cycle, cpu_hold=0, done=0, word_count=3, no 4th write.
- rst asserted during the WRITE of word 7: all outputs 0 next cycle. A new start then writes from addr 0.
- With IMEM_LOADER_CHECKSUM_EN:
  - A correct XOR byte gives chk_err=0, done=1.
  - A checksum byte XORed with 0x01 gives chk_err=1, done=1.
